// File: rtl/clk_tick_gen_if.sv
// Configuration write port of clk_tick_gen: a valid/ready handshake that carries
// the target channel, its new half-period and its enable.
interface clk_tick_gen_if #(
  parameter int NCH   = 4,
  parameter int DIV_W = 32
);
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [DIV_W-1:0] cfg_half;
  logic             cfg_en;

  modport master (output cfg_valid, cfg_ch, cfg_half, cfg_en, input cfg_ready);
  modport slave  (input cfg_valid, cfg_ch, cfg_half, cfg_en, output cfg_ready);
endinterface

// File: rtl/clk_tick_gen.sv
// Free-running cycle counter plus NCH run-time programmable tick/square-wave channels.
// Optional build macro CLKDIV_SYNC_START_EN adds a 'sync' input that restarts all running channels.
module clk_tick_gen #(
  parameter int CNT_W    = 32,
  parameter int NCH      = 4,
  parameter int DIV_W    = 32,
  parameter int DEF_HALF = 2_500_000
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef CLKDIV_SYNC_START_EN
  input  logic             sync,
`endif
  clk_tick_gen_if.slave    cfg,
  output logic [CNT_W-1:0] free_cnt,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   sq
);
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_COMMIT = 1'b1
  } cfg_state_t;

  cfg_state_t       state_r;
  cfg_state_t       state_nxt_s;
  logic             ready_nxt_s;
  logic             cfg_ready_r;
  logic             accept_s;
  logic             commit_s;
  logic             sync_s;
  logic [CH_W-1:0]  cap_ch_r;
  logic [DIV_W-1:0] cap_half_r;
  logic             cap_en_r;
  logic [CNT_W-1:0] free_cnt_r;

`ifdef CLKDIV_SYNC_START_EN
  assign sync_s = sync;
`else
  assign sync_s = 1'b0;
`endif

  assign accept_s      = (state_r == ST_IDLE) && cfg.cfg_valid;
  assign commit_s      = (state_r == ST_COMMIT);
  assign cfg.cfg_ready = cfg_ready_r;
  assign free_cnt      = free_cnt_r;

  // Free-running counter; wraps from all-ones to zero without a flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      free_cnt_r <= {CNT_W{1'b0}};
    end else begin
      free_cnt_r <= free_cnt_r + CNT_W'(1);
    end
  end

  // Config FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Config FSM next state: a write always spends exactly one cycle in COMMIT
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cfg.cfg_valid) begin
          state_nxt_s = ST_COMMIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_COMMIT: state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // Config FSM output decode, taken from the next state so cfg_ready can be a flop
  always_comb begin
    ready_nxt_s = 1'b1;
    case (state_nxt_s)
      ST_IDLE:   ready_nxt_s = 1'b1;
      ST_COMMIT: ready_nxt_s = 1'b0;
      default:   ready_nxt_s = 1'b1;
    endcase
  end

  // Registered ready flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_ready_r <= 1'b1;
    end else begin
      cfg_ready_r <= ready_nxt_s;
    end
  end

  // Capture the accepted write so the requester may change its data right away
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_ch_r   <= {CH_W{1'b0}};
      cap_half_r <= {DIV_W{1'b0}};
      cap_en_r   <= 1'b0;
    end else if (accept_s) begin
      cap_ch_r   <= cfg.cfg_ch;
      cap_half_r <= cfg.cfg_half;
      cap_en_r   <= cfg.cfg_en;
    end else begin
      cap_ch_r   <= cap_ch_r;
      cap_half_r <= cap_half_r;
      cap_en_r   <= cap_en_r;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [DIV_W-1:0] cnt_r;
    logic [DIV_W-1:0] half_r;
    logic             en_r;
    logic             sq_r;
    logic             tick_r;
    logic             hit_s;
    logic             run_s;
    logic             wrap_s;

    // An out-of-range captured index matches no channel, so the write is dropped
    assign hit_s  = commit_s && (cap_ch_r == CH_W'(c));
    assign run_s  = en_r && (half_r != {DIV_W{1'b0}});
    assign wrap_s = (cnt_r == (half_r - DIV_W'(1)));

    // Channel divider: reconfigure, hold idle, restart on sync, or count toward a toggle
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_r  <= {DIV_W{1'b0}};
        half_r <= DIV_W'(DEF_HALF);
        en_r   <= 1'b1;
        sq_r   <= 1'b0;
        tick_r <= 1'b0;
      end else if (hit_s) begin
        half_r <= cap_half_r;
        en_r   <= cap_en_r;
        cnt_r  <= {DIV_W{1'b0}};
        sq_r   <= 1'b0;
        tick_r <= 1'b0;
      end else if (!run_s || sync_s) begin
        cnt_r  <= {DIV_W{1'b0}};
        sq_r   <= 1'b0;
        tick_r <= 1'b0;
      end else if (wrap_s) begin
        cnt_r  <= {DIV_W{1'b0}};
        sq_r   <= ~sq_r;
        tick_r <= 1'b1;
      end else begin
        cnt_r  <= cnt_r + DIV_W'(1);
        tick_r <= 1'b0;
      end
    end

    assign tick[c] = tick_r;
    assign sq[c]   = sq_r;
  end

endmodule

// File: tb/tb_clk_tick_gen.sv
// Bench for clk_tick_gen: constant vector table, hand-written corner sequences and
// random configuration traffic checked against a restart-time arithmetic model.
module tb_clk_tick_gen;
  localparam int NCH      = 3;
  localparam int DIV_W    = 8;
  localparam int CNT_W    = 4;
  localparam int DEF_HALF = 4;

  logic             clk    = 1'b0;
  logic             rst_n  = 1'b0;
  logic             sync_i = 1'b0;
  logic [CNT_W-1:0] free_cnt;
  logic [NCH-1:0]   tick;
  logic [NCH-1:0]   sq;

  clk_tick_gen_if #(.NCH(NCH), .DIV_W(DIV_W)) ifc ();

  clk_tick_gen #(
    .CNT_W   (CNT_W),
    .NCH     (NCH),
    .DIV_W   (DIV_W),
    .DEF_HALF(DEF_HALF)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
`ifdef CLKDIV_SYNC_START_EN
    .sync    (sync_i),
`endif
    .cfg     (ifc),
    .free_cnt(free_cnt),
    .tick    (tick),
    .sq      (sq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: each channel remembers the cycle it last (re)started; outputs follow by arithmetic
  int n;
  int t0   [NCH];
  int mh   [NCH];
  bit men  [NCH];
  bit m_ready;
  int p_ch;
  int p_half;
  bit p_en;

  function automatic bit m_run(input int c);
    return men[c] && (mh[c] != 0);
  endfunction

  function automatic logic [NCH-1:0] m_tick();
    logic [NCH-1:0] r = '0;
    for (int c = 0; c < NCH; c++)
      if (m_run(c) && (n - t0[c]) > 0 && ((n - t0[c]) % mh[c]) == 0) r[c] = 1'b1;
    return r;
  endfunction

  function automatic logic [NCH-1:0] m_sq();
    logic [NCH-1:0] r = '0;
    for (int c = 0; c < NCH; c++)
      if (m_run(c) && (((n - t0[c]) / mh[c]) % 2) == 1) r[c] = 1'b1;
    return r;
  endfunction

  task automatic m_reset();
    n = 0;
    m_ready = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      t0[c]  = 0;
      mh[c]  = DEF_HALF;
      men[c] = 1'b1;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, n);
    end
  endtask

  // One clock cycle: drive inputs, advance the model across the edge, compare everything
  task automatic cycle(input bit v, input int ch, input int h, input bit e, input bit s);
    ifc.cfg_valid = v;
    ifc.cfg_ch    = 2'(ch);
    ifc.cfg_half  = 8'(h);
    ifc.cfg_en    = e;
    sync_i        = s;
    @(posedge clk);
    n++;
    if (!m_ready) begin
      if (p_ch < NCH) begin
        mh[p_ch]  = p_half;
        men[p_ch] = p_en;
        t0[p_ch]  = n;
      end
      m_ready = 1'b1;
    end else if (v) begin
      p_ch    = ch;
      p_half  = h;
      p_en    = e;
      m_ready = 1'b0;
    end
    if (s)
      for (int c = 0; c < NCH; c++)
        if (m_run(c)) t0[c] = n;
    #1;
    check("free_cnt", int'(free_cnt), n % 16);
    check("cfg_ready", int'(ifc.cfg_ready), int'(m_ready));
    check("tick", int'(tick), int'(m_tick()));
    check("sq", int'(sq), int'(m_sq()));
  endtask

  typedef struct {
    bit       v;
    int       ch;
    int       h;
    bit       e;
    bit       ready;
    bit [2:0] tk;
    bit [2:0] sqv;
    int       fc;
  } vec_t;

  vec_t vec [25];

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected test end");
    $fatal(1);
  end

  initial begin
    // Cycles 1..20 after reset, then a ch1 half=1 write at cycle 21
    vec[0]  = '{1'b0, 0, 0, 1'b0, 1'b1, 3'b000, 3'b000, 1};
    vec[1]  = '{1'b0, 0, 0, 1'b0, 1'b1, 3'b000, 3'b000, 2};
    vec[2]  = '{1'b0, 0, 0, 1'b0, 1'b1, 3'b000, 3'b000, 3};
    vec[3]  = '{1'b0, 0, 0, 1'b0, 1'b1, 3'b111, 3'b111, 4};
    vec[4]  = '{1'b0, 0, 0, 1'b0, 1'b1, 3'b000, 3'b111, 5};
    vec[5]  = '{1'b0, 0, 0, 1'b0, 1'b1, 3'b000, 3'b111, 6};
    vec[6]  = '{1'b0, 0, 0, 1'b0, 1'b1, 3'b000, 3'b111, 7};
    vec[7]  = '{1'b0, 0, 0, 1'b0, 1'b1, 3'b111, 3'b000, 8};
    vec[8]  = '{1'b0, 0, 0, 1'b0, 1'b1, 3'b000, 3'b000, 9};
    vec[9]  = '{1'b0, 0, 0, 1'b0, 1'b1, 3'b000, 3'b000, 10};
    vec[10] = '{1'b0, 0, 0, 1'b0, 1'b1, 3'b000, 3'b000, 11};
    vec[11] = '{1'b0, 0, 0, 1'b0, 1'b1, 3'b111, 3'b111, 12};
    vec[12] = '{1'b0, 0, 0, 1'b0, 1'b1, 3'b000, 3'b111, 13};
    vec[13] = '{1'b0, 0, 0, 1'b0, 1'b1, 3'b000, 3'b111, 14};
    vec[14] = '{1'b0, 0, 0, 1'b0, 1'b1, 3'b000, 3'b111, 15};
    vec[15] = '{1'b0, 0, 0, 1'b0, 1'b1, 3'b111, 3'b000, 0};
    vec[16] = '{1'b0, 0, 0, 1'b0, 1'b1, 3'b000, 3'b000, 1};
    vec[17] = '{1'b0, 0, 0, 1'b0, 1'b1, 3'b000, 3'b000, 2};
    vec[18] = '{1'b0, 0, 0, 1'b0, 1'b1, 3'b000, 3'b000, 3};
    vec[19] = '{1'b0, 0, 0, 1'b0, 1'b1, 3'b111, 3'b111, 4};
    vec[20] = '{1'b1, 1, 1, 1'b1, 1'b0, 3'b000, 3'b111, 5};
    vec[21] = '{1'b0, 0, 0, 1'b0, 1'b1, 3'b000, 3'b101, 6};
    vec[22] = '{1'b0, 0, 0, 1'b0, 1'b1, 3'b010, 3'b111, 7};
    vec[23] = '{1'b0, 0, 0, 1'b0, 1'b1, 3'b111, 3'b000, 8};
    vec[24] = '{1'b0, 0, 0, 1'b0, 1'b1, 3'b010, 3'b010, 9};

    ifc.cfg_valid = 1'b0;
    ifc.cfg_ch    = '0;
    ifc.cfg_half  = '0;
    ifc.cfg_en    = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_free_cnt", int'(free_cnt), 0);
    check("rst_ready", int'(ifc.cfg_ready), 1);
    check("rst_tick", int'(tick), 0);
    check("rst_sq", int'(sq), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 25; i++) begin
      cycle(vec[i].v, vec[i].ch, vec[i].h, vec[i].e, 1'b0);
      check($sformatf("vec%0d_ready", i), int'(ifc.cfg_ready), int'(vec[i].ready));
      check($sformatf("vec%0d_tick", i), int'(tick), int'(vec[i].tk));
      check($sformatf("vec%0d_sq", i), int'(sq), int'(vec[i].sqv));
      check($sformatf("vec%0d_free", i), int'(free_cnt), vec[i].fc);
    end

    // Valid held four cycles with changing data: only the 1st and 3rd are taken
    cycle(1'b1, 0, 2, 1'b1, 1'b0);
    check("hold_ready0", int'(ifc.cfg_ready), 0);
    cycle(1'b1, 0, 3, 1'b1, 1'b0);
    check("hold_ready1", int'(ifc.cfg_ready), 1);
    cycle(1'b1, 0, 4, 1'b1, 1'b0);
    check("hold_ready2", int'(ifc.cfg_ready), 0);
    cycle(1'b1, 0, 5, 1'b1, 1'b0);
    check("hold_ready3", int'(ifc.cfg_ready), 1);
    for (int k = 1; k <= 4; k++) begin
      cycle(1'b0, 0, 0, 1'b0, 1'b0);
      check($sformatf("hold_tick0_k%0d", k), int'(tick[0]), (k == 4) ? 1 : 0);
    end
    check("hold_sq0", int'(sq[0]), 1);

    // half=0 and en=0 both park the channel low
    cycle(1'b1, 0, 0, 1'b1, 1'b0);
    cycle(1'b0, 0, 0, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      cycle(1'b0, 0, 0, 1'b0, 1'b0);
      check("half0_tick0", int'(tick[0]), 0);
      check("half0_sq0", int'(sq[0]), 0);
    end
    cycle(1'b1, 0, 7, 1'b0, 1'b0);
    cycle(1'b0, 0, 0, 1'b0, 1'b0);
    for (int k = 0; k < 16; k++) begin
      cycle(1'b0, 0, 0, 1'b0, 1'b0);
      check("dis_tick0", int'(tick[0]), 0);
      check("dis_sq0", int'(sq[0]), 0);
    end

    // Random writes, including out-of-range channel 3
    for (int k = 0; k < 400; k++) begin
      bit s;
      s = 1'b0;
`ifdef CLKDIV_SYNC_START_EN
      s = ($urandom_range(0, 15) == 0);
`endif
      cycle(($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 6)), ($urandom_range(0, 4) != 0), s);
    end

`ifdef CLKDIV_SYNC_START_EN
    cycle(1'b0, 0, 0, 1'b0, 1'b0);
    cycle(1'b1, 0, 3, 1'b1, 1'b0);
    cycle(1'b0, 0, 0, 1'b0, 1'b0);
    cycle(1'b1, 1, 5, 1'b1, 1'b0);
    cycle(1'b0, 0, 0, 1'b0, 1'b0);
    repeat (4) cycle(1'b0, 0, 0, 1'b0, 1'b0);
    cycle(1'b0, 0, 0, 1'b0, 1'b1);
    check("sync_sq", int'(sq[1:0]), 0);
    for (int k = 1; k <= 5; k++) begin
      cycle(1'b0, 0, 0, 1'b0, 1'b0);
      check($sformatf("sync_tick0_k%0d", k), int'(tick[0]), (k == 3) ? 1 : 0);
      check($sformatf("sync_tick1_k%0d", k), int'(tick[1]), (k == 5) ? 1 : 0);
    end
`endif

    // Asynchronous reset in the middle of a COMMIT
    cycle(1'b0, 0, 0, 1'b0, 1'b0);
    cycle(1'b1, 2, 6, 1'b1, 1'b0);
    check("mid_commit_ready", int'(ifc.cfg_ready), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_free_cnt", int'(free_cnt), 0);
    check("async_tick", int'(tick), 0);
    check("async_sq", int'(sq), 0);
    check("async_ready", int'(ifc.cfg_ready), 1);
    m_reset();
    ifc.cfg_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      cycle(1'b0, 0, 0, 1'b0, 1'b0);
      check($sformatf("rerst_tick_k%0d", k), int'(tick), (k % 4 == 0) ? 7 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
